// File: rtl/regfile_write_arbiter.sv
// Register-file write-back arbiter: ALU and load-unit holding slots plus an optional
// single-cycle branch-with-link write into R14 (enabled by defining WB_LINK_EN).
module regfile_write_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        aluValid,
    input  logic [3:0]  aluDest,
    input  logic [31:0] aluData,
    output logic        aluReady,
    input  logic        memValid,
    input  logic [3:0]  memDest,
    input  logic [31:0] memData,
    output logic        memReady,
    input  logic        linkReq,
    input  logic [31:0] linkPC,
    output logic        writeEnable,
    output logic [3:0]  writeDestination,
    output logic [31:0] writeData,
    output logic        writeToPC,
    output logic        busy
);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_LINK,
        GRANT_ALU,
        GRANT_MEM
    } grant_t;

    typedef enum logic {
        PTR_ALU,
        PTR_MEM
    } pointer_t;

    localparam logic [3:0] LINK_REG = 4'hE;
    localparam logic [3:0] PC_REG   = 4'hF;

    logic        slotAluFull;
    logic [3:0]  slotAluDest;
    logic [31:0] slotAluData;
    logic        slotMemFull;
    logic [3:0]  slotMemDest;
    logic [31:0] slotMemData;
    logic        ageMemOlder;
    pointer_t    rrPointer;

    grant_t      grant;
    logic        linkActive;
    logic        aluTake;
    logic        memTake;

`ifdef WB_LINK_EN
    assign linkActive = linkReq;
`else
    logic unusedLink;
    assign unusedLink = ^{linkReq, linkPC};
    assign linkActive = 1'b0;
`endif

    // Link wins outright; equal destinations force oldest-first so the later value lands last.
    always_comb begin
        // NOTE: default assigned first so every path drives grant and no latch is inferred.
        grant = GRANT_NONE;
        if (linkActive) begin
            grant = GRANT_LINK;
        end else if (slotAluFull && slotMemFull) begin
            if (slotAluDest == slotMemDest) begin
                grant = ageMemOlder ? GRANT_MEM : GRANT_ALU;
            end else begin
                grant = (rrPointer == PTR_MEM) ? GRANT_MEM : GRANT_ALU;
            end
        end else if (slotAluFull) begin
            grant = GRANT_ALU;
        end else if (slotMemFull) begin
            grant = GRANT_MEM;
        end
    end

    assign aluReady = !reset && (!slotAluFull || grant == GRANT_ALU);
    assign memReady = !reset && (!slotMemFull || grant == GRANT_MEM);
    assign aluTake  = aluValid && aluReady;
    assign memTake  = memValid && memReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            slotAluFull      <= 1'b0;
            slotAluDest      <= '0;
            slotAluData      <= '0;
            slotMemFull      <= 1'b0;
            slotMemDest      <= '0;
            slotMemData      <= '0;
            ageMemOlder      <= 1'b0;
            rrPointer        <= PTR_ALU;
            writeEnable      <= 1'b0;
            writeDestination <= '0;
            writeData        <= '0;
        end else begin
            case (grant)
                GRANT_LINK: begin
                    writeEnable      <= 1'b1;
                    writeDestination <= LINK_REG;
                    writeData        <= linkPC;
                end
                GRANT_ALU: begin
                    writeEnable      <= 1'b1;
                    writeDestination <= slotAluDest;
                    writeData        <= slotAluData;
                    rrPointer        <= PTR_MEM;
                end
                GRANT_MEM: begin
                    writeEnable      <= 1'b1;
                    writeDestination <= slotMemDest;
                    writeData        <= slotMemData;
                    rrPointer        <= PTR_ALU;
                end
                default: begin
                    writeEnable      <= 1'b0;
                end
            endcase

            if (aluTake) begin
                slotAluFull <= 1'b1;
                slotAluDest <= aluDest;
                slotAluData <= aluData;
            end else if (grant == GRANT_ALU) begin
                slotAluFull <= 1'b0;
            end

            if (memTake) begin
                slotMemFull <= 1'b1;
                slotMemDest <= memDest;
                slotMemData <= memData;
            end else if (grant == GRANT_MEM) begin
                slotMemFull <= 1'b0;
            end

            // A freshly captured entry is younger than whatever stays in the other slot.
            if (aluTake && memTake) begin
                ageMemOlder <= 1'b0;
            end else if (aluTake) begin
                ageMemOlder <= 1'b1;
            end else if (memTake) begin
                ageMemOlder <= 1'b0;
            end
        end
    end

    assign writeToPC = writeEnable && (writeDestination == PC_REG);
    assign busy      = slotAluFull | slotMemFull;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a timestamp-ordered slot model,
// plus directed write-back scenarios; link cases run only when WB_LINK_EN is defined.
module tb_regfile_write_arbiter;

`ifdef WB_LINK_EN
    localparam bit LINK_EN = 1'b1;
`else
    localparam bit LINK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        aluValid;
    logic [3:0]  aluDest;
    logic [31:0] aluData;
    logic        aluReady;
    logic        memValid;
    logic [3:0]  memDest;
    logic [31:0] memData;
    logic        memReady;
    logic        linkReq;
    logic [31:0] linkPC;
    logic        writeEnable;
    logic [3:0]  writeDestination;
    logic [31:0] writeData;
    logic        writeToPC;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .aluValid         (aluValid),
        .aluDest          (aluDest),
        .aluData          (aluData),
        .aluReady         (aluReady),
        .memValid         (memValid),
        .memDest          (memDest),
        .memData          (memData),
        .memReady         (memReady),
        .linkReq          (linkReq),
        .linkPC           (linkPC),
        .writeEnable      (writeEnable),
        .writeDestination (writeDestination),
        .writeData        (writeData),
        .writeToPC        (writeToPC),
        .busy             (busy)
    );

    // Model: each source holds at most one entry stamped with its capture cycle.
    bit          mAFull, mMFull;
    logic [3:0]  mADest, mMDest;
    logic [31:0] mAData, mMData;
    int          mATime, mMTime;
    bit          mNextIsMem;
    bit          mWe;
    logic [3:0]  mWDest;
    logic [31:0] mWData;
    int          cycleNo = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycleNo);
        end
    endtask

    // One clock cycle: drive, compare visible outputs and readies, then advance the model.
    task automatic step(input bit rst, input bit av, input logic [3:0] ad, input logic [31:0] adata,
                        input bit mv, input logic [3:0] md, input logic [31:0] mdata,
                        input bit lk, input logic [31:0] pc);
        bit linkNow, pickAlu, pickMem, expAR, expMR, takeA, takeM;
        @(negedge clk);
        reset = rst; aluValid = av; aluDest = ad; aluData = adata;
        memValid = mv; memDest = md; memData = mdata; linkReq = lk; linkPC = pc;
        #1;
        linkNow = LINK_EN && lk;
        pickAlu = 1'b0;
        pickMem = 1'b0;
        if (!linkNow) begin
            if (mAFull && mMFull) begin
                if (mADest == mMDest) begin
                    pickAlu = (mATime <= mMTime);
                    pickMem = !pickAlu;
                end else begin
                    pickMem = mNextIsMem;
                    pickAlu = !mNextIsMem;
                end
            end else begin
                pickAlu = mAFull;
                pickMem = mMFull && !mAFull;
            end
        end
        expAR = !rst && (!mAFull || pickAlu);
        expMR = !rst && (!mMFull || pickMem);
        check("aluReady", 32'(aluReady), 32'(expAR));
        check("memReady", 32'(memReady), 32'(expMR));
        check("busy", 32'(busy), 32'(mAFull || mMFull));
        check("writeEnable", 32'(writeEnable), 32'(mWe));
        check("writeDestination", 32'(writeDestination), 32'(mWDest));
        check("writeData", writeData, mWData);
        check("writeToPC", 32'(writeToPC), 32'(mWe && mWDest == 4'd15));
        @(posedge clk);
        cycleNo++;
        if (rst) begin
            mAFull = 0; mMFull = 0; mNextIsMem = 0;
            mWe = 0; mWDest = '0; mWData = '0;
        end else begin
            takeA = av && expAR;
            takeM = mv && expMR;
            mWe = 1'b0;
            if (linkNow) begin
                mWe = 1; mWDest = 4'hE; mWData = pc;
            end else if (pickAlu) begin
                mWe = 1; mWDest = mADest; mWData = mAData; mAFull = 0; mNextIsMem = 1;
            end else if (pickMem) begin
                mWe = 1; mWDest = mMDest; mWData = mMData; mMFull = 0; mNextIsMem = 0;
            end
            if (takeA) begin
                mAFull = 1; mADest = ad; mAData = adata; mATime = cycleNo;
            end
            if (takeM) begin
                mMFull = 1; mMDest = md; mMData = mdata; mMTime = cycleNo;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 32'd0);
    endtask

    task automatic doReset();
        step(1, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 32'd0);
    endtask

    initial begin
        mAFull = 0; mMFull = 0; mNextIsMem = 0; mATime = 0; mMTime = 0;
        mADest = '0; mMDest = '0; mAData = '0; mMData = '0;
        mWe = 0; mWDest = '0; mWData = '0;
        reset = 1; aluValid = 0; aluDest = '0; aluData = '0;
        memValid = 0; memDest = '0; memData = '0; linkReq = 0; linkPC = '0;

        // Reset with live requests present; they must be discarded.
        step(1, 1, 4'd7, 32'hDEAD, 1, 4'd8, 32'hBEEF, 1, 32'h44);
        doReset();
        idle();

        // Single ALU write appears two edges after acceptance, for one cycle.
        step(0, 1, 4'd3, 32'h11, 0, 4'd0, 32'd0, 0, 32'd0);
        idle();
        #1;
        check("single_we", 32'(writeEnable), 32'd1);
        check("single_dest", 32'(writeDestination), 32'd3);
        check("single_data", writeData, 32'h11);
        idle();
        #1;
        check("single_we_drop", 32'(writeEnable), 32'd0);
        check("single_data_hold", writeData, 32'h11);

        // Simultaneous capture: ALU first, MEM next, then idle.
        doReset();
        step(0, 1, 4'd1, 32'hA, 1, 4'd2, 32'hB, 0, 32'd0);
        idle();
        #1;
        check("both_first", writeData, 32'hA);
        idle();
        #1;
        check("both_second", writeData, 32'hB);
        check("both_busy", 32'(busy), 32'd0);

        // Same destination: older MEM value lands before the ALU value.
        doReset();
        step(0, 0, 4'd0, 32'd0, 1, 4'd5, 32'h55, 0, 32'd0);
        step(0, 1, 4'd5, 32'h66, 0, 4'd0, 32'd0, 0, 32'd0);
        #1;
        check("order_first", writeData, 32'h55);
        idle();
        #1;
        check("order_second", writeData, 32'h66);

        // Write to R15 raises writeToPC with writeEnable.
        step(0, 1, 4'd15, 32'h200, 0, 4'd0, 32'd0, 0, 32'd0);
        idle();
        #1;
        check("pc_flag", 32'(writeToPC), 32'd1);
        check("pc_data", writeData, 32'h200);

`ifdef WB_LINK_EN
        // Link preempts two full slots, which then drain in round-robin order.
        doReset();
        step(0, 1, 4'd1, 32'hA, 1, 4'd2, 32'hB, 0, 32'd0);
        step(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, 32'h100);
        #1;
        check("link_dest", 32'(writeDestination), 32'hE);
        check("link_data", writeData, 32'h100);
        idle();
        #1;
        check("link_drain1", writeData, 32'hA);
        idle();
        #1;
        check("link_drain2", writeData, 32'hB);
`endif

        // Reset while both slots are full drops them.
        doReset();
        step(0, 1, 4'd4, 32'h44, 1, 4'd6, 32'h66, 0, 32'd0);
        doReset();
        #1;
        check("rst_we", 32'(writeEnable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", writeData, 32'd0);
        idle();
        #1;
        check("rst_no_write", 32'(writeEnable), 32'd0);

        // Randomized traffic; small destination range exercises the equal-destination rule.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] ad, md;
            ad = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            md = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 2) != 0, ad, $urandom,
                 $urandom_range(0, 2) != 0, md, $urandom,
                 $urandom_range(0, 5) == 0, $urandom);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
